vedic_pp_combine: RTL and testbench

- Byte-serial combiner stage of the Vedic multiplier. It consumes the four N×N partial products of one 2N×2N Vedic multiply and produces the 4N-bit product.
- Uses one instance of the team's 8-bit ripple-carry adder, rca_8bit (ports A, B, Cin, Sum, Cout), time-multiplexed one byte per clock.
- Sits directly upstream of that adder: it drives the adder's operands and carry-in, and consumes its Sum/Cout.
- Feeds the next recursion level of the multiplier through a valid/ready handshake.

---
 rtl/vedic_pp_combine.sv | 139 +++++++++++++
 tb/tb_vedic_pp_combine.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_pp_combine.sv
// Byte-serial partial-product combiner for one Vedic multiplier level; product valid 2*NB
// edges after accept, held in DONE until out_ready, no new input accepted outside IDLE.

module rca_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Cout
);

  logic [8:0] c;

  always_comb begin
    c    = '0;
    Sum  = '0;
    c[0] = Cin;
    for (int i = 0; i < 8; i++) begin
      Sum[i] = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  assign Cout = c[8];

endmodule

module vedic_pp_combine #(
  parameter int N = 8  // half-operand width; must be even and >= 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] q0,
  input  logic [2*N-1:0] q1,
  input  logic [2*N-1:0] q2,
  input  logic [2*N-1:0] q3,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*N-1:0] product,
  output logic           busy
);

  localparam int NB = 4 * N / 8;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD1 = 2'd1;
  localparam logic [1:0] S_ADD2 = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [4*N-1:0] acc_q, acc_d;
  logic           carry_q, carry_d;
  logic [KW-1:0]  k_q, k_d;
  logic [2*N-1:0] q1_q, q1_d;
  logic [2*N-1:0] q2_q, q2_d;

  logic [4*N-1:0] addend;
  logic [7:0]     add_a;
  logic [7:0]     add_b;
  logic [7:0]     add_sum;
  logic           add_cout;

  // The middle terms both sit at bit N, so each pass adds one zero-extended shifted copy.
  assign addend = {{N{1'b0}}, (state_q == S_ADD2) ? q2_q : q1_q, {N{1'b0}}};
  assign add_a  = acc_q[{k_q, 3'b000} +: 8];
  assign add_b  = addend[{k_q, 3'b000} +: 8];

  rca_8bit u_rca (
    .A    (add_a),
    .B    (add_b),
    .Cin  (carry_q),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    k_d     = k_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d   = {q3, q0};
          q1_d    = q1;
          q2_d    = q2;
          k_d     = '0;
          carry_d = 1'b0;
          state_d = S_ADD1;
        end
      end
      S_ADD1, S_ADD2: begin
        acc_d[{k_q, 3'b000} +: 8] = add_sum;
        carry_d = add_cout;
        k_d     = k_q + 1'b1;
        // Top-byte carry is always zero for genuine partial products, so it is dropped.
        if (k_q == K_LAST) begin
          k_d     = '0;
          carry_d = 1'b0;
          state_d = (state_q == S_ADD1) ? S_ADD2 : S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      q1_q    <= '0;
      q2_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_ADD1) || (state_q == S_ADD2);
  assign out_valid = (state_q == S_DONE);
  assign product   = acc_q;

endmodule

// File: tb/tb_vedic_pp_combine.sv
// Directed bench for vedic_pp_combine (N=8) against an arithmetic/timing model.
module tb_vedic_pp_combine;

  localparam int N  = 8;
  localparam int NB = 4 * N / 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] q0, q1, q2, q3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  vedic_pp_combine #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a transaction is "busy" for 2*NB edges after acceptance, then waits for out_ready.
  localparam int M_IDLE = 0, M_BUSY = 1, M_DONE = 2;
  int          m_st     = M_IDLE;
  int          m_cnt    = 0;
  logic [31:0] m_prod   = '0;
  bit          m_pknown = 1'b1;
  int          cyc      = 0;
  int          n_acc    = 0;
  int          acc_last = 0;
  int          acc_prev = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_st     = M_IDLE;
      m_cnt    = 0;
      m_prod   = '0;
      m_pknown = 1'b1;
    end else begin
      cyc++;
      case (m_st)
        M_IDLE: if (in_valid) begin
          m_prod   = 32'(q0) + (32'(q1) << N) + (32'(q2) << N) + (32'(q3) << (2 * N));
          m_pknown = 1'b0;
          m_cnt    = 0;
          m_st     = M_BUSY;
          acc_prev = acc_last;
          acc_last = cyc;
          n_acc++;
        end
        M_BUSY: begin
          m_cnt++;
          if (m_cnt == 2 * NB) begin
            m_st     = M_DONE;
            m_pknown = 1'b1;
          end
        end
        default: if (out_ready) m_st = M_IDLE;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_st == M_IDLE));
      chk("busy", 32'(busy), 32'(m_st == M_BUSY));
      chk("out_valid", 32'(out_valid), 32'(m_st == M_DONE));
      if (m_pknown) chk("product", product, m_prod);
      if (busy && int'(dut.k_q) == NB - 1) chk("final_cout", 32'(dut.add_cout), 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] a2, input logic [15:0] a3);
    q0 = a0; q1 = a1; q2 = a2; q3 = a3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input logic [31:0] exp, input int exp_lat, input string nm,
                          output int nbusy);
    int lat;
    lat   = 0;
    nbusy = busy ? 1 : 0;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
      if (busy) nbusy++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_product"}, product, exp);
  endtask

  initial begin
    int nb;
    bit seen;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q0 = '0; q1 = '0; q2 = '0; q3 = '0;
    #1 rst = 1'b1;
    repeat (2) tick();
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_product", product, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // zero operands
    out_ready = 1'b1;
    send(16'h0, 16'h0, 16'h0, 16'h0);
    wait_out(32'h0, 2 * NB, "zero", nb);
    chk("zero_busy_cycles", 32'(nb), 32'(2 * NB));
    tick();
    chk("zero_release_in_ready", 32'(in_ready), 32'h1);
    chk("zero_release_out_valid", 32'(out_valid), 32'h0);

    // maximum operands: 0xFFFF * 0xFFFF
    send(16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01);
    wait_out(32'hFFFE0001, 2 * NB, "max", nb);
    tick();

    // 0x1234 * 0x5678; after the first pass acc = 0x060C1860 + 0x00087000
    send(16'h1860, 16'h0870, 16'h1178, 16'h060C);
    repeat (NB) tick();
    chk("carry_mid_acc", product, 32'h06148860);
    wait_out(32'h06260060, NB, "carry", nb);
    tick();

    // backpressure with ignored input pulses
    out_ready = 1'b0;
    send(16'h1860, 16'h0870, 16'h1178, 16'h060C);
    wait_out(32'h06260060, 2 * NB, "bp", nb);
    for (int i = 0; i < 5; i++) begin
      q0 = 16'hFE01; q1 = 16'hFE01; q2 = 16'hFE01; q3 = 16'hFE01;
      in_valid = (i % 2 == 0);
      tick();
      chk("bp_hold_product", product, 32'h06260060);
      chk("bp_hold_in_ready", 32'(in_ready), 32'h0);
      chk("bp_hold_out_valid", 32'(out_valid), 32'h1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_out_valid", 32'(out_valid), 32'h0);
    chk("bp_release_in_ready", 32'(in_ready), 32'h1);
    tick();

    // reset in the middle of the second pass
    send(16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01);
    repeat (6) tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'h1);
    chk("midrst_product", product, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    send(16'h1860, 16'h0870, 16'h1178, 16'h060C);
    wait_out(32'h06260060, 2 * NB, "postrst", nb);
    tick();

    // back-to-back: operands change right after the first accept
    q0 = 16'hFE01; q1 = 16'hFE01; q2 = 16'hFE01; q3 = 16'hFE01;
    in_valid = 1'b1;
    tick();
    q0 = 16'h1860; q1 = 16'h0870; q2 = 16'h1178; q3 = 16'h060C;
    seen = 1'b0;
    for (int i = 0; i < 40 && n_acc < 8; i++) begin
      tick();
      if (!seen && out_valid) begin
        chk("b2b_first_product", product, 32'hFFFE0001);
        seen = 1'b1;
      end
      if (acc_last == cyc) break;
    end
    in_valid = 1'b0;
    chk("b2b_first_seen", 32'(seen), 32'h1);
    chk("b2b_accept_spacing", 32'(acc_last - acc_prev), 32'(2 * NB + 2));
    wait_out(32'h06260060, 2 * NB, "b2b_second", nb);
    tick();
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
